// File: rtl/exe_issue_ctrl_pkg.sv
// Shared definitions for the execute-stage issue controller: ALU op bit
// positions, the mul/div op group and the controller state encoding.
package exe_issue_ctrl_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;
  localparam int OP_MUL  = 12;
  localparam int OP_MULH = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV  = 15;
  localparam int OP_DIVU = 16;
  localparam int OP_MOD  = 17;
  localparam int OP_MODU = 18;

  // Ops that take more than one cycle in the ALU (bits 12..18)
  localparam logic [18:0] MULDIV_MASK = 19'h7F000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } es_state_e;

  function automatic logic is_muldiv(input logic [18:0] op);
    return |(op & MULDIV_MASK);
  endfunction

endpackage

// File: rtl/exe_issue_ctrl.sv
// Execute-stage issue/hold controller between the ID/EX boundary and the ALU.
// Holds the ALU inputs stable until complete, buffers the result under MEM
// backpressure, and drains an in-flight mul/div cleanly on flush.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   EMPTY    | no live op, ready to accept from ID
//   BUSY     | op driven to ALU, waiting for alu_complete
//   DONE     | result captured in the buffer, waiting for MEM allowin
//   DRAIN    | flushed mul/div still running in the ALU, result discarded
module exe_issue_ctrl
  import exe_issue_ctrl_pkg::*;
#(
  parameter int OP_W   = 19,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_to_es_valid,
  output logic              es_allowin,
  input  logic [OP_W-1:0]   ds_op,
  input  logic [DATA_W-1:0] ds_src1,
  input  logic [DATA_W-1:0] ds_src2,
  input  logic [REG_W-1:0]  ds_dest,
  input  logic              ds_gr_we,
  input  logic [31:0]       ds_pc,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_complete,
  input  logic              flush,
  output logic              es_to_ms_valid,
  input  logic              ms_allowin,
  output logic [DATA_W-1:0] es_result,
  output logic [REG_W-1:0]  es_dest,
  output logic              es_gr_we,
  output logic [31:0]       es_pc,
  output logic              es_busy,
  output logic [REG_W-1:0]  es_busy_dest
);

  es_state_e         state;
  logic [DATA_W-1:0] res_buf;
  logic              xfer_out;
  logic              accept;
  logic              st_empty, st_busy, st_done;

  assign st_empty = (state == ST_EMPTY);
  assign st_busy  = (state == ST_BUSY);
  assign st_done  = (state == ST_DONE);

  assign es_to_ms_valid = ~flush & ((st_busy & alu_complete) | st_done);
  assign xfer_out       = es_to_ms_valid & ms_allowin;
  assign es_allowin     = ~flush & (st_empty | xfer_out);
  assign accept         = ds_to_es_valid & es_allowin;

  assign es_result    = st_done ? res_buf : alu_result;
  assign es_busy      = st_busy & ~alu_complete & es_gr_we;
  assign es_busy_dest = es_dest;

  // Operands and sideband only change on accept, so a held op stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_src1 <= '0;
      alu_src2 <= '0;
      es_dest  <= '0;
      es_gr_we <= 1'b0;
      es_pc    <= '0;
    end else if (accept) begin
      alu_src1 <= ds_src1;
      alu_src2 <= ds_src2;
      es_dest  <= ds_dest;
      es_gr_we <= ds_gr_we;
      es_pc    <= ds_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      alu_op  <= '0;
      res_buf <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            alu_op <= ds_op;
            state  <= ST_BUSY;
          end else begin
            alu_op <= '0;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            // A running mul/div keeps its inputs so it can finish cleanly.
            if (is_muldiv(alu_op) && !alu_complete) begin
              state <= ST_DRAIN;
            end else begin
              state  <= ST_EMPTY;
              alu_op <= '0;
            end
          end else if (alu_complete) begin
            if (ms_allowin) begin
              if (accept) begin
                alu_op <= ds_op;
              end else begin
                state  <= ST_EMPTY;
                alu_op <= '0;
              end
            end else begin
              state   <= ST_DONE;
              res_buf <= alu_result;
              alu_op  <= '0;
            end
          end
        end
        ST_DONE: begin
          if (flush) begin
            state  <= ST_EMPTY;
            alu_op <= '0;
          end else if (ms_allowin) begin
            if (accept) begin
              alu_op <= ds_op;
              state  <= ST_BUSY;
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
        ST_DRAIN: begin
          if (alu_complete) begin
            state  <= ST_EMPTY;
            alu_op <= '0;
          end
        end
        default: begin
          state  <= ST_EMPTY;
          alu_op <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/exe_issue_ctrl.md
Name: exe_issue_ctrl

Overview:
- Execute-stage issue and hold controller. It sits between the ID/EX pipeline boundary and the ALU.
- Latches one decoded operation from ID and drives a stable alu_op/alu_src1/alu_src2 until the ALU raises complete.
- Buffers the result when MEM backpressures, and hands it to MEM with a valid/allowin handshake.
- Also handles flush while a multi-cycle mul/div is in flight, and reports busy status to ID for RAW interlock.

Parameters:
OP_W, 19, ALU one-hot op width (bits 12..18 are mul/mulh/mulhu/div/divu/mod/modu)
DATA_W, 32, operand/result width
REG_W, 5, destination register index width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
ds_to_es_valid  in  1  ID presents an operation
es_allowin  out  1  EX accepts an operation this cycle
ds_op  in  OP_W  one-hot ALU op from ID
ds_src1  in  DATA_W  operand 1
ds_src2  in  DATA_W  operand 2
ds_dest  in  REG_W  destination register
ds_gr_we  in  1  register write enable
ds_pc  in  32  instruction PC
alu_op  out  OP_W  to ALU, registered
alu_src1  out  DATA_W  to ALU, registered
alu_src2  out  DATA_W  to ALU, registered
alu_result  in  DATA_W  from ALU
alu_complete  in  1  from ALU, combinational
flush  in  1  exception/ertn cancel of EX contents
es_to_ms_valid  out  1  result valid to MEM
ms_allowin  in  1  MEM accepts
es_result  out  DATA_W  result to MEM
es_dest  out  REG_W  destination to MEM
es_gr_we  out  1  write enable to MEM
es_pc  out  32  PC to MEM
es_busy  out  1  EX holds a live op whose result is not yet available (ID stalls on dest match)
es_busy_dest  out  REG_W  dest of that op (valid when es_busy)

Behaviour:
- States: EMPTY, BUSY (op driven to ALU, waiting on complete), DONE (result captured, waiting for MEM), DRAIN (flushed op still in the ALU).
- Reset (async):
  - state=EMPTY.
  - alu_op, alu_src1, alu_src2, es_result buffer, es_dest, es_pc = 0; es_gr_we = 0.
  - Outputs: es_to_ms_valid=0, es_busy=0, es_allowin=1.
- Handshakes:
  - xfer_out = es_to_ms_valid & ms_allowin.
  - es_to_ms_valid = ~flush & ((BUSY & alu_complete) | DONE).
  - es_allowin = ~flush & (EMPTY | xfer_out).
  - accept = ds_to_es_valid & es_allowin.
- es_result = DONE ? buffered result : alu_result.
- Transitions:
  - EMPTY --accept--> BUSY: load alu_op/alu_src1/alu_src2/dest/gr_we/pc from ds_*.
  - BUSY & complete & ms_allowin & ~flush: if accept, reload and stay BUSY; else go to EMPTY and clear alu_op to 0.
  - BUSY & complete & ~ms_allowin & ~flush: go to DONE, capture alu_result, clear alu_op to 0 (ALU idle).
  - DONE & ms_allowin & ~flush: accept ? BUSY (reload) : EMPTY.
  - flush in EMPTY/DONE: go to EMPTY, clear alu_op to 0; nothing passes to MEM.
  - flush in BUSY with mul/div op (alu_op[18:12] nonzero) & ~alu_complete: go to DRAIN, hold alu_op/srcs unchanged so the divider/multiplier finishes cleanly.
  - flush in BUSY with a single-cycle op, or with alu_complete=1: go to EMPTY.
  - DRAIN: es_to_ms_valid=0, es_allowin=0. On alu_complete go to EMPTY, clear alu_op, discard the result. A flush during DRAIN has no further effect.
- Latency:
  - Single-cycle ops: valid to MEM in the same cycle as BUSY is entered +0, i.e. one cycle after accept.
  - mul*: complete one cycle after entering BUSY.
  - div/mod: per divider completion.
- Back-to-back mul: reload on the completion cycle keeps alu_op asserted. The multiplier's complete toggles back to 0, so the second mul completes two cycles after reload. Required: no stale complete is taken.
- es_busy = (BUSY & ~alu_complete) | DRAIN is excluded (the flushed op writes nothing), so es_busy = BUSY & ~alu_complete & ds-gr_we-latched. es_busy_dest = es_dest.
- Reset asserted mid-op: immediate EMPTY, all outputs to reset values. The ALU is reset by the same source.

Decomposition:
- Shared package: ALU op bit-index constants (OP_ADD=0 … OP_MODU=18), MULDIV_MASK = bits 12..18, and the state encoding (2-bit: EMPTY=0, BUSY=1, DONE=2, DRAIN=3).
- No sub-module is needed. The result/sideband holding register stays inline.

Test Plan:
- add: src1=5, src2=7, ms_allowin=1 -> es_to_ms_valid=1 with es_result=12 one cycle after accept; es_allowin=1 in that cycle; a back-to-back sub 12-5 produces 7 the next cycle.
- mul with backpressure: mul 0xFFFF×0x10000, ms_allowin=0 for 3 cycles -> DONE holds es_result=0xFFFF0000, alu_op=0; on ms_allowin=1 exactly one transfer occurs.
- Back-to-back mulh (-2)×3 then mulhu 0xFFFFFFFF×2 -> results 0xFFFFFFFF then 0x00000001; each completes two cycles after its accept.
- divu 100/7 flushed one cycle after accept -> DRAIN, es_to_ms_valid stays 0 until the divider completes; then EMPTY; a following add is accepted and its result is correct.
- Reset asserted during BUSY with div -> the next cycle shows state EMPTY, es_to_ms_valid=0, alu_op=0, es_allowin=1.
- RAW interlock: div to r4 in BUSY -> es_busy=1, es_busy_dest=4 until the completion cycle, then 0.
